// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, taken-branch flush,
// and a multicycle multiply/divide sequencer with a 63-cycle timeout.
module pipe_stall_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_ir_en,
  output logic        md_p_en,
  output logic        md_sel,
  output logic        md_ex,
  output logic        md_busy,
  output logic [5:0]  md_cycles
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned FIELD_W  = 5;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(63);
  localparam logic [FIELD_W-1:0] OP_ALU    = FIELD_W'(5'b00000);
  localparam logic [FIELD_W-1:0] OP_LW     = FIELD_W'(5'b01000);
  localparam logic [FIELD_W-1:0] ALU_MULT  = FIELD_W'(5'b00110);
  localparam logic [FIELD_W-1:0] ALU_DIV   = FIELD_W'(5'b00111);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] md_cycles_q, md_cycles_d;
  logic             md_ex_q, md_ex_d;

  logic [FIELD_W-1:0] dx_op, dx_alu, dx_rd, fd_rs, fd_rt;
  logic               dx_is_mult, dx_is_div, dx_is_lw, load_use;

  // Field extraction and instruction classification
  assign dx_op  = dx_ir[31:27];
  assign dx_rd  = dx_ir[26:22];
  assign dx_alu = dx_ir[6:2];
  assign fd_rs  = fd_ir[21:17];
  assign fd_rt  = fd_ir[16:12];

  assign dx_is_mult = (dx_op == OP_ALU) && (dx_alu == ALU_MULT);
  assign dx_is_div  = (dx_op == OP_ALU) && (dx_alu == ALU_DIV);
  assign dx_is_lw   = (dx_op == OP_LW);
  assign load_use   = dx_is_lw && (dx_rd != '0) &&
                      ((fd_rs == dx_rd) || (fd_rt == dx_rd));

  // Fields this controller never looks at
  logic unused_ir_bits;
  assign unused_ir_bits = ^{fd_ir[31:22], fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  // State, latency counter and result flags; reset aborts any operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      md_cycles_q <= '0;
      md_ex_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_cycles_q <= md_cycles_d;
      md_ex_q     <= md_ex_d;
    end
  end

  // Next-state and combinational enables/flushes/pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    md_cycles_d  = md_cycles_q;
    md_ex_d      = md_ex_q;
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    dx_en        = 1'b1;
    xm_en        = 1'b1;
    mw_en        = 1'b1;
    fd_flush     = 1'b0;
    dx_flush     = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_ir_en     = 1'b0;
    md_p_en      = 1'b0;
    md_sel       = 1'b0;
    md_busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (dx_is_mult || dx_is_div) begin
          state_d = START;
        end else if (load_use) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          dx_flush = 1'b1;
        end
      end
      START: begin
        pc_en        = 1'b0;
        fd_en        = 1'b0;
        dx_en        = 1'b0;
        xm_en        = 1'b0;
        md_busy      = 1'b1;
        md_ctrl_mult = dx_is_mult;
        md_ctrl_div  = dx_is_div;
        md_ir_en     = 1'b1;
        cnt_d        = '0;
        md_ex_d      = 1'b0;
        state_d      = WAIT;
      end
      WAIT: begin
        pc_en   = 1'b0;
        fd_en   = 1'b0;
        dx_en   = 1'b0;
        xm_en   = 1'b0;
        md_busy = 1'b1;
        if (md_ready) begin
          md_p_en     = 1'b1;
          md_ex_d     = md_exception;
          md_cycles_d = cnt_q;
          state_d     = DONE;
        end else if (cnt_q == CNT_MAX) begin
          md_p_en     = 1'b1;
          md_ex_d     = 1'b1;
          md_cycles_d = cnt_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        md_sel  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_cycles = md_cycles_q;
  assign md_ex     = md_ex_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_ir, dx_ir;
  logic        branch_taken, md_ready, md_exception;
  logic        pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush;
  logic        md_ctrl_mult, md_ctrl_div, md_ir_en, md_p_en, md_sel, md_ex, md_busy;
  logic [5:0]  md_cycles;
  logic [6:0]  en_vec;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stall_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .fd_ir        (fd_ir),
    .dx_ir        (dx_ir),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .xm_en        (xm_en),
    .mw_en        (mw_en),
    .fd_flush     (fd_flush),
    .dx_flush     (dx_flush),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_ir_en     (md_ir_en),
    .md_p_en      (md_p_en),
    .md_sel       (md_sel),
    .md_ex        (md_ex),
    .md_busy      (md_busy),
    .md_cycles    (md_cycles)
  );

  always #5 clock = ~clock;

  // {pc, fd, dx, xm, mw, fd_flush, dx_flush}
  assign en_vec = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush};

  localparam logic [6:0] EN_RUN    = 7'b1111100;
  localparam logic [6:0] EN_MDSTL  = 7'b0000100;
  localparam logic [6:0] EN_LDUSE  = 7'b0011101;
  localparam logic [6:0] EN_BRANCH = 7'b1111111;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue a multdiv op from IDLE and follow it through DONE and back to IDLE.
  // ready_at = WAIT cycle (1-based) carrying md_ready, 0 = never.
  task automatic run_md(input string tag, input logic [31:0] ir, input bit is_div,
                        input int ready_at, input bit exc, input bit hold_ready,
                        input logic [5:0] exp_cyc, input bit exp_ex);
    int exp_wait, stall_n, pend_n, pulse_n, other_n;
    exp_wait = (ready_at > 0) ? ready_at : 64;
    stall_n = 0; pend_n = 0; pulse_n = 0; other_n = 0;
    dx_ir = ir; fd_ir = '0; md_ready = 1'b0; md_exception = exc; branch_taken = 1'b0;
    #2;
    check_eq({tag, "_idle_en"}, 32'(en_vec), 32'(EN_RUN));
    check_eq({tag, "_idle_busy"}, 32'(md_busy), 32'd0);
    next_cycle(); #2;
    check_eq({tag, "_start_en"}, 32'(en_vec), 32'(EN_MDSTL));
    check_eq({tag, "_start_busy"}, 32'(md_busy), 32'd1);
    check_eq({tag, "_start_iren"}, 32'(md_ir_en), 32'd1);
    if (en_vec[6:3] == 4'b0000) stall_n++;
    pulse_n += is_div ? int'(md_ctrl_div) : int'(md_ctrl_mult);
    other_n += is_div ? int'(md_ctrl_mult) : int'(md_ctrl_div);
    pend_n  += int'(md_p_en);
    for (int w = 1; w <= exp_wait; w++) begin
      next_cycle();
      md_ready = (w == ready_at);
      #2;
      check_eq({tag, "_wait_busy"}, 32'(md_busy), 32'd1);
      check_eq({tag, "_wait_pen"}, 32'(md_p_en), 32'(w == exp_wait));
      if (en_vec[6:3] == 4'b0000) stall_n++;
      pulse_n += is_div ? int'(md_ctrl_div) : int'(md_ctrl_mult);
      other_n += is_div ? int'(md_ctrl_mult) : int'(md_ctrl_div);
      pend_n  += int'(md_p_en);
    end
    next_cycle();
    md_ready = hold_ready;
    dx_ir = '0;
    #2;
    check_eq({tag, "_done_sel"}, 32'(md_sel), 32'd1);
    check_eq({tag, "_done_en"}, 32'(en_vec), 32'(EN_RUN));
    check_eq({tag, "_done_busy"}, 32'(md_busy), 32'd0);
    check_eq({tag, "_done_ex"}, 32'(md_ex), 32'(exp_ex));
    check_eq({tag, "_done_cycles"}, 32'(md_cycles), 32'(exp_cyc));
    pend_n  += int'(md_p_en);
    pulse_n += is_div ? int'(md_ctrl_div) : int'(md_ctrl_mult);
    next_cycle(); #2;
    check_eq({tag, "_idle2_sel"}, 32'(md_sel), 32'd0);
    check_eq({tag, "_idle2_busy"}, 32'(md_busy), 32'd0);
    check_eq({tag, "_idle2_ex"}, 32'(md_ex), 32'(exp_ex));
    check_eq({tag, "_idle2_cycles"}, 32'(md_cycles), 32'(exp_cyc));
    pend_n  += int'(md_p_en);
    check_eq({tag, "_stall_cycles"}, 32'(stall_n), 32'(1 + exp_wait));
    check_eq({tag, "_pen_pulses"}, 32'(pend_n), 32'd1);
    check_eq({tag, "_start_pulses"}, 32'(pulse_n), 32'd1);
    check_eq({tag, "_wrong_pulses"}, 32'(other_n), 32'd0);
    md_ready = 1'b0;
    md_exception = 1'b0;
  endtask

  // Load-use stall for one cycle, then the flushed nop clears it
  task automatic run_lw(input string tag, input logic [31:0] lw_ir, input logic [31:0] f_ir,
                        input logic [6:0] exp_en);
    dx_ir = lw_ir; fd_ir = f_ir; branch_taken = 1'b0;
    #2;
    check_eq({tag, "_en"}, 32'(en_vec), 32'(exp_en));
    next_cycle();
    dx_ir = '0;
    #2;
    check_eq({tag, "_after_en"}, 32'(en_vec), 32'(EN_RUN));
    next_cycle();
    fd_ir = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] mult_ir, div_ir;
    mult_ir = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110);
    div_ir  = mk(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00111);

    reset = 1'b1; fd_ir = '0; dx_ir = '0;
    branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    #2;
    check_eq("rst_en", 32'(en_vec), 32'(EN_RUN));
    check_eq("rst_md_pulses", 32'({md_ctrl_mult, md_ctrl_div, md_ir_en, md_p_en, md_sel, md_busy}), 32'd0);
    check_eq("rst_cycles", 32'(md_cycles), 32'd0);
    check_eq("rst_ex", 32'(md_ex), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    run_md("mult17", mult_ir, 1'b0, 17, 1'b0, 1'b0, 6'd16, 1'b0);
    run_md("mult_exc", mult_ir, 1'b0, 1, 1'b1, 1'b1, 6'd0, 1'b1);
    run_md("div_tmo", div_ir, 1'b1, 0, 1'b0, 1'b0, 6'd63, 1'b1);

    run_lw("lu_rs", mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0), mk(5'b00000, 5'd9, 5'd5, 5'd7, 5'd0), EN_LDUSE);
    run_lw("lu_rt", mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0), mk(5'b00000, 5'd9, 5'd3, 5'd5, 5'd0), EN_LDUSE);
    run_lw("lu_rd0", mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0), mk(5'b00000, 5'd9, 5'd0, 5'd0, 5'd0), EN_RUN);
    run_lw("lu_nomatch", mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0), mk(5'b00000, 5'd9, 5'd6, 5'd7, 5'd0), EN_RUN);

    // Branch beats a load-use hazard
    dx_ir = mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
    fd_ir = mk(5'b00000, 5'd9, 5'd5, 5'd7, 5'd0);
    branch_taken = 1'b1;
    #2;
    check_eq("br_lu_en", 32'(en_vec), 32'(EN_BRANCH));
    // Branch beats a multdiv start
    next_cycle();
    dx_ir = mult_ir; fd_ir = '0;
    #2;
    check_eq("br_md_en", 32'(en_vec), 32'(EN_BRANCH));
    next_cycle();
    branch_taken = 1'b0; dx_ir = '0;
    #2;
    check_eq("br_md_no_start", 32'(md_busy), 32'd0);
    next_cycle();

    // Reset in the middle of WAIT aborts the operation
    dx_ir = mult_ir;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    #2;
    check_eq("rw_busy_before", 32'(md_busy), 32'd1);
    #1;
    md_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("rw_busy", 32'(md_busy), 32'd0);
    check_eq("rw_pen", 32'(md_p_en), 32'd0);
    check_eq("rw_ex", 32'(md_ex), 32'd0);
    check_eq("rw_cycles", 32'(md_cycles), 32'd0);
    check_eq("rw_en", 32'(en_vec), 32'(EN_RUN));
    next_cycle();
    dx_ir = '0;
    reset = 1'b0;
    #2;
    check_eq("rw_late_ready_pen", 32'(md_p_en), 32'd0);
    check_eq("rw_late_ready_busy", 32'(md_busy), 32'd0);
    next_cycle(); #2;
    check_eq("rw_late_ready_pen2", 32'(md_p_en), 32'd0);
    check_eq("rw_late_ex", 32'(md_ex), 32'd0);
    check_eq("rw_late_cycles", 32'(md_cycles), 32'd0);
    check_eq("rw_late_sel", 32'(md_sel), 32'd0);
    md_ready = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have the port: clock  in  1  single system clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port: reset  in  1  asynchronous, active-high; forces the block to IDLE immediately.
REQ-003 The block SHALL have the port: fd_ir  in  32  instruction in the F/D latch.
REQ-004 The block SHALL have the port: dx_ir  in  32  instruction in the D/X latch.
REQ-005 The block SHALL have the port: branch_taken  in  1  taken branch/jump resolved in the X stage.
REQ-006 The block SHALL have the port: md_ready  in  1  multdiv result valid.
REQ-007 The block SHALL have the port: md_exception  in  1  multdiv exception, qualified by md_ready.
REQ-008 The block SHALL have the ports: pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each  pipeline register enables.
REQ-009 The block SHALL have the ports: fd_flush, dx_flush  out  1 each  load a nop (32'b0) into the named latch.
REQ-010 The block SHALL have the ports: md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle multdiv start pulses.
REQ-011 The block SHALL have the ports: md_ir_en, md_p_en  out  1 each  enables for the multdiv IR capture latch and the multdiv product latch.
REQ-012 The block SHALL have the ports: md_sel, md_ex  out  1 each  X-stage result mux select and exception flag.
REQ-013 The block SHALL have the port: md_busy  out  1  high in states START and WAIT.
REQ-014 The block SHALL have the port: md_cycles  out  6  latency of the last multdiv operation.

Function
REQ-015 Decode SHALL use these fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
REQ-016 Decode SHALL classify: mult = opcode 00000 and ALU op 00110; div = opcode 00000 and ALU op 00111; lw = opcode 01000.
REQ-017 The FSM SHALL have the states IDLE, START, WAIT and DONE, encoded in 2 bits.
REQ-018 IDLE SHALL go to START when dx_ir is mult or div and branch_taken=0.
REQ-019 START SHALL last exactly one cycle; in START, md_ctrl_mult or md_ctrl_div (per the decode) =1, md_ir_en=1, md_cycles counter cleared to 0; START then goes to WAIT.
REQ-020 In START and WAIT, pc_en=fd_en=dx_en=xm_en=0 and mw_en=1, so older instructions drain and nothing advances into or past X.
REQ-021 In WAIT, the internal counter SHALL increment once per cycle and saturate at 63.
REQ-022 On md_ready=1 in WAIT, the block SHALL assert md_p_en=1 that cycle, register md_ex<=md_exception, and go to DONE.
REQ-023 Timeout: if the counter reaches 63 in WAIT with md_ready=0, the block SHALL assert md_p_en=1, register md_ex<=1, and go to DONE.
REQ-024 In DONE, all enables SHALL be 1 and md_sel=1 (the multdiv instruction advances X->M with the product); DONE SHALL go to IDLE after one cycle.
REQ-025 On leaving WAIT, md_cycles SHALL be loaded with the counter value and held until the next START.
REQ-026 md_ex SHALL hold its value until the next START, where it is cleared.
REQ-027 Load-use stall in IDLE: when dx_ir is lw, rd≠0, and (fd rs==rd or fd rt==rd), the block SHALL drive pc_en=0, fd_en=0 and dx_flush=1, with the other enables =1.
REQ-028 Branch in IDLE: when branch_taken=1, the block SHALL drive fd_flush=1, dx_flush=1 and all enables =1.
REQ-029 Priority in IDLE SHALL be branch_taken > multdiv start > load-use.
REQ-030 md_ready SHALL be ignored in IDLE, START and DONE.
REQ-031 branch_taken and the load-use stall SHALL be ignored in START and WAIT.
REQ-032 Enables, flushes and md_sel SHALL be combinational from state and decode; pulses and flags SHALL be state-driven with no extra latency.

Reset
REQ-033 Reset SHALL force state=IDLE, counter=0, md_cycles=0 and md_ex=0, asynchronously.
REQ-034 During reset, md_ctrl_mult, md_ctrl_div, md_ir_en, md_p_en, md_sel and md_busy SHALL be 0.
REQ-035 During reset, enables and flushes SHALL follow the IDLE rules; with fd_ir=dx_ir=0, all enables =1 and all flushes =0.
REQ-036 Reset asserted in START or WAIT SHALL abort the operation, with no md_p_en pulse and md_ex=0.

Verification
REQ-037 The bench SHALL cover: dx_ir=mult (ALU op 00110), md_ready at the 17th WAIT cycle -> one md_ctrl_mult pulse; pc/fd/dx/xm_en low for 18 cycles; md_p_en for 1 cycle; md_sel in DONE; md_cycles=16; md_ex=0.
REQ-038 The bench SHALL cover: dx_ir=div, md_ready never asserted -> md_ex=1 and md_cycles=63 after timeout; DONE for 1 cycle; then IDLE.
REQ-039 The bench SHALL cover: dx_ir=lw with rd=5, fd_ir rs=5 -> pc_en=fd_en=0 and dx_flush=1 for exactly 1 cycle; with rd=0 -> no stall.
REQ-040 The bench SHALL cover: branch_taken=1 with a load-use condition present -> fd_flush=dx_flush=1, all enables 1, no stall.
REQ-041 The bench SHALL cover: reset pulsed mid-WAIT -> immediate IDLE; md_busy=0, md_ex=0, md_cycles=0; md_ready arriving afterwards is ignored.
REQ-042 The bench SHALL cover: md_ready=1 with md_exception=1 in the first WAIT cycle -> md_cycles=0 and md_ex=1; md_ready held high in DONE causes no second md_p_en.
